// File: rtl/agc_alarm_pkg.sv
// Shared types and constants for the alarm/restart sequencer: FSM states,
// cause indices and the lowest-index priority encoder.
package agc_alarm_pkg;

  localparam int CAUSE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JAM  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CAUSE_W-1:0] CAUSE_TCTRAP     = 3'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_RUPTLOCK   = 3'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_NIGHTWATCH = 3'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_PARITY     = 3'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_OSCFAIL    = 3'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_VFAIL      = 3'd5;
  localparam logic [CAUSE_W-1:0] CAUSE_SCAFAL     = 3'd6;
  localparam logic [CAUSE_W-1:0] CAUSE_PIPAFL     = 3'd7;

  // Bit 0 is the highest-priority alarm, so scan downward and let the lowest set bit win.
  function automatic logic [CAUSE_W-1:0] lowest_set(input logic [7:0] v);
    logic [CAUSE_W-1:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = CAUSE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/alarm_warn_filter.sv
// Tick-strobed saturating up/down counter driving WARN with hysteresis:
// WARN sets at WARN_THR and only clears once the count has drained to zero.
module alarm_warn_filter #(
  parameter int FILT_MAX = 15,
  parameter int WARN_THR = 8
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic TICK,
  input  logic act,
  output logic WARN
);

  localparam int CW = $clog2(FILT_MAX + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (TICK) begin
      if (act) begin
        if (cnt != CW'(FILT_MAX)) cnt_nxt = cnt + CW'(1);
      end else if (cnt != '0) begin
        cnt_nxt = cnt - CW'(1);
      end
    end
  end

  // WARN tracks the count being written so it asserts on the same edge the threshold is reached.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      cnt  <= '0;
      WARN <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (cnt_nxt >= CW'(WARN_THR)) WARN <= 1'b1;
      else if (cnt_nxt == '0)       WARN <= 1'b0;
    end
  end

endmodule

// File: rtl/alarm_restart_sequencer.sv
// Alarm/restart controller: edge-triggered restart FSM, GOJAM pulse, sticky lamp/cause
// and filtered WARN. Defining ALARM_LOG_EN adds a 4-entry cause log FIFO.
module alarm_restart_sequencer
  import agc_alarm_pkg::*;
#(
  parameter int         NSRC         = 8,
  parameter logic [7:0] RESTART_MASK = 8'h3F,
  parameter int         JAM_CYCLES   = 4,
  parameter int         FILT_MAX     = 15,
  parameter int         WARN_THR     = 8
) (
  input  logic               CLOCK,
  input  logic               rst,
  input  logic [NSRC-1:0]    ALM_REQ,
  input  logic               TICK,
  input  logic               ERRST,
  output logic               GOJAM,
  output logic               RESTRT,
  output logic [CAUSE_W-1:0] CAUSE,
  output logic               CAUSE_VLD,
  output logic               WARN,
  output logic [NSRC-1:0]    ALM_STK
`ifdef ALARM_LOG_EN
  ,
  input  logic               LOG_POP,
  output logic [CAUSE_W-1:0] LOG_DATA,
  output logic               LOG_EMPTY,
  output logic               LOG_OVF
`endif
);

  localparam int JW = (JAM_CYCLES > 1) ? $clog2(JAM_CYCLES) : 1;
  localparam logic [JW-1:0] JAM_LAST = JW'(JAM_CYCLES - 1);
  localparam logic [NSRC-1:0] MASK = RESTART_MASK[NSRC-1:0];

  state_t             state;
  state_t             state_nxt;
  logic [JW-1:0]      jam_cnt;
  logic [NSRC-1:0]    prev;
  logic [NSRC-1:0]    rise;
  logic [7:0]         rise8;
  logic [CAUSE_W-1:0] cause_nxt;
  logic               start_jam;
  logic               errst_ok;

  assign rise = ALM_REQ & ~prev & MASK;

  always_comb begin
    rise8             = '0;
    rise8[NSRC-1:0]   = rise;
    cause_nxt         = lowest_set(rise8);
  end

  // A new restart may only start outside JAM; in HOLD a fresh rise wins over the return to IDLE.
  always_comb begin
    state_nxt = state;
    start_jam = 1'b0;
    errst_ok  = 1'b0;
    case (state)
      IDLE: begin
        errst_ok = ERRST;
        if (|rise) begin
          start_jam = 1'b1;
          state_nxt = JAM;
        end
      end
      JAM: begin
        if (jam_cnt == JAM_LAST) state_nxt = HOLD;
      end
      HOLD: begin
        errst_ok = ERRST;
        if (|rise) begin
          start_jam = 1'b1;
          state_nxt = JAM;
        end else if ((ALM_REQ & MASK) == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state   <= IDLE;
      jam_cnt <= '0;
      prev    <= '0;
    end else begin
      state <= state_nxt;
      prev  <= ALM_REQ;
      if (start_jam)         jam_cnt <= '0;
      else if (state == JAM) jam_cnt <= jam_cnt + JW'(1);
    end
  end

  assign GOJAM = (state == JAM);

  // A restart in the same cycle as ERRST keeps the lamp lit with the new cause, but the sticky alarms still clear.
  always_ff @(posedge CLOCK) begin
    if (rst) begin
      RESTRT    <= 1'b0;
      CAUSE     <= '0;
      CAUSE_VLD <= 1'b0;
      ALM_STK   <= '0;
    end else begin
      if (start_jam) begin
        RESTRT    <= 1'b1;
        CAUSE     <= cause_nxt;
        CAUSE_VLD <= 1'b1;
      end else if (errst_ok) begin
        RESTRT    <= 1'b0;
        CAUSE     <= '0;
        CAUSE_VLD <= 1'b0;
      end
      ALM_STK <= errst_ok ? '0 : (ALM_STK | ALM_REQ);
    end
  end

  alarm_warn_filter #(
    .FILT_MAX (FILT_MAX),
    .WARN_THR (WARN_THR)
  ) u_filter (
    .CLOCK (CLOCK),
    .rst   (rst),
    .TICK  (TICK),
    .act   ((|ALM_REQ) | RESTRT),
    .WARN  (WARN)
  );

`ifdef ALARM_LOG_EN
  logic [CAUSE_W-1:0] log_mem [4];
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [2:0]         log_cnt;
  logic               log_full;
  logic               do_pop;
  logic               do_push;

  assign LOG_EMPTY = (log_cnt == 3'd0);
  assign log_full  = (log_cnt == 3'd4);
  assign do_pop    = LOG_POP & ~LOG_EMPTY;
  // A pop frees the slot the simultaneous push needs, so a full log still accepts it.
  assign do_push   = start_jam & (~log_full | do_pop);
  assign LOG_DATA  = log_mem[rd_ptr];

  always_ff @(posedge CLOCK) begin
    if (do_push) log_mem[wr_ptr] <= cause_nxt;
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      log_cnt <= '0;
      LOG_OVF <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   log_cnt <= log_cnt + 3'd1;
        2'b01:   log_cnt <= log_cnt - 3'd1;
        default: log_cnt <= log_cnt;
      endcase
      if (start_jam & ~do_push) LOG_OVF <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alarm_restart_sequencer.sv
// Directed bench for alarm_restart_sequencer: a vector table for the basic restart
// sequence plus hand-written multi-cycle scenarios (log checks when ALARM_LOG_EN is set).
module tb_alarm_restart_sequencer;

  logic       CLOCK;
  logic       rst;
  logic [7:0] ALM_REQ;
  logic       TICK;
  logic       ERRST;
  logic       GOJAM;
  logic       RESTRT;
  logic [2:0] CAUSE;
  logic       CAUSE_VLD;
  logic       WARN;
  logic [7:0] ALM_STK;
`ifdef ALARM_LOG_EN
  logic       LOG_POP;
  logic [2:0] LOG_DATA;
  logic       LOG_EMPTY;
  logic       LOG_OVF;
`endif

  int compared;
  int mismatched;

  alarm_restart_sequencer dut (
    .CLOCK     (CLOCK),
    .rst       (rst),
    .ALM_REQ   (ALM_REQ),
    .TICK      (TICK),
    .ERRST     (ERRST),
    .GOJAM     (GOJAM),
    .RESTRT    (RESTRT),
    .CAUSE     (CAUSE),
    .CAUSE_VLD (CAUSE_VLD),
    .WARN      (WARN),
    .ALM_STK   (ALM_STK)
`ifdef ALARM_LOG_EN
    ,
    .LOG_POP   (LOG_POP),
    .LOG_DATA  (LOG_DATA),
    .LOG_EMPTY (LOG_EMPTY),
    .LOG_OVF   (LOG_OVF)
`endif
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [7:0] req;
    logic       errst;
    logic       gojam;
    logic       restrt;
    logic [2:0] cause;
    logic       vld;
    logic       warn;
    logic [7:0] stk;
  } vec_t;

  vec_t vecs[13];

  // Inputs are driven 1 time unit after a rising edge and outputs sampled at the same offset.
  task automatic applyStimulus(input logic [7:0] req, input logic tick, input logic errst);
    ALM_REQ = req;
    TICK    = tick;
    ERRST   = errst;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int gcount;
    compared   = 0;
    mismatched = 0;
    ALM_REQ    = '0;
    TICK       = 1'b0;
    ERRST      = 1'b0;
`ifdef ALARM_LOG_EN
    LOG_POP    = 1'b0;
`endif

    //           req    errst gojam restrt cause vld  warn  stk
    vecs[0]  = '{8'h04, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 8'h04};
    vecs[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 8'h04};
    vecs[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 8'h04};
    vecs[3]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 8'h04};
    vecs[4]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 8'h04};
    vecs[5]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{8'h0A, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 8'h0A};
    vecs[7]  = '{8'h01, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 8'h0B};
    vecs[8]  = '{8'h01, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 8'h0B};
    vecs[9]  = '{8'h01, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 8'h0B};
    vecs[10] = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'h0B};
    vecs[11] = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'h0B};
    vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'h0B};

    doReset();
    checkOutput("rst_gojam",  {7'd0, GOJAM},     8'h00);
    checkOutput("rst_restrt", {7'd0, RESTRT},    8'h00);
    checkOutput("rst_cause",  {5'd0, CAUSE},     8'h00);
    checkOutput("rst_vld",    {7'd0, CAUSE_VLD}, 8'h00);
    checkOutput("rst_warn",   {7'd0, WARN},      8'h00);
    checkOutput("rst_stk",    ALM_STK,           8'h00);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].req, 1'b0, vecs[i].errst);
      checkOutput($sformatf("v%0d_gojam", i),  {7'd0, GOJAM},     {7'd0, vecs[i].gojam});
      checkOutput($sformatf("v%0d_restrt", i), {7'd0, RESTRT},    {7'd0, vecs[i].restrt});
      checkOutput($sformatf("v%0d_cause", i),  {5'd0, CAUSE},     {5'd0, vecs[i].cause});
      checkOutput($sformatf("v%0d_vld", i),    {7'd0, CAUSE_VLD}, {7'd0, vecs[i].vld});
      checkOutput($sformatf("v%0d_warn", i),   {7'd0, WARN},      {7'd0, vecs[i].warn});
      checkOutput($sformatf("v%0d_stk", i),    ALM_STK,           vecs[i].stk);
    end

    // Held request gives one pulse; a new rise during HOLD restarts directly; drop and re-raise restarts again.
    doReset();
    gcount = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'h08, 1'b0, 1'b0);
      if (GOJAM) gcount++;
    end
    checkOutput("held_pulse_len", 8'(gcount), 8'd4);
    checkOutput("held_cause", {5'd0, CAUSE}, 8'd3);
    checkOutput("held_restrt", {7'd0, RESTRT}, 8'h01);
    applyStimulus(8'h0A, 1'b0, 1'b0);
    checkOutput("hold_rise_gojam", {7'd0, GOJAM}, 8'h01);
    checkOutput("hold_rise_cause", {5'd0, CAUSE}, 8'd1);
    gcount = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'h08, 1'b0, 1'b0);
      if (GOJAM) gcount++;
    end
    checkOutput("hold_rise_rest", 8'(gcount), 8'd3);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("drop_gojam", {7'd0, GOJAM}, 8'h00);
    gcount = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h08, 1'b0, 1'b0);
      if (GOJAM) gcount++;
    end
    checkOutput("reraise_pulse_len", 8'(gcount), 8'd4);
    checkOutput("reraise_cause", {5'd0, CAUSE}, 8'd3);

    // Warning-only source drives the filter up to saturation and back down through the hysteresis band.
    doReset();
    gcount = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(8'h80, 1'b1, 1'b0);
      if (GOJAM) gcount++;
    end
    checkOutput("warn_tick7", {7'd0, WARN}, 8'h00);
    applyStimulus(8'h80, 1'b1, 1'b0);
    if (GOJAM) gcount++;
    checkOutput("warn_tick8", {7'd0, WARN}, 8'h01);
    checkOutput("warnonly_no_gojam", 8'(gcount), 8'd0);
    checkOutput("warnonly_restrt", {7'd0, RESTRT}, 8'h00);
    checkOutput("warnonly_stk", ALM_STK, 8'h80);
    for (int i = 0; i < 10; i++) applyStimulus(8'h80, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkOutput("errst_stk_clr", ALM_STK, 8'h00);
    for (int i = 0; i < 13; i++) applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("warn_hyst_cnt1", {7'd0, WARN}, 8'h01);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("warn_tick_frozen", {7'd0, WARN}, 8'h01);
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("warn_clear_cnt0", {7'd0, WARN}, 8'h00);

    // ERRST ignored in JAM, honoured in HOLD; reset in the middle of JAM kills the pulse.
    doReset();
    applyStimulus(8'h04, 1'b0, 1'b0);
    applyStimulus(8'h04, 1'b0, 1'b1);
    checkOutput("jam_errst_restrt", {7'd0, RESTRT}, 8'h01);
    checkOutput("jam_errst_vld", {7'd0, CAUSE_VLD}, 8'h01);
    checkOutput("jam_errst_stk", ALM_STK, 8'h04);
    for (int i = 0; i < 3; i++) applyStimulus(8'h04, 1'b0, 1'b0);
    checkOutput("in_hold_gojam", {7'd0, GOJAM}, 8'h00);
    applyStimulus(8'h04, 1'b0, 1'b1);
    checkOutput("hold_errst_restrt", {7'd0, RESTRT}, 8'h00);
    checkOutput("hold_errst_vld", {7'd0, CAUSE_VLD}, 8'h00);
    checkOutput("hold_errst_cause", {5'd0, CAUSE}, 8'h00);
    checkOutput("hold_errst_stk", ALM_STK, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    checkOutput("jam2_gojam", {7'd0, GOJAM}, 8'h01);
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("rst_mid_jam_gojam", {7'd0, GOJAM}, 8'h00);
    gcount = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0);
      if (GOJAM) gcount++;
    end
    checkOutput("no_replay", 8'(gcount), 8'd0);
    applyStimulus(8'h10, 1'b0, 1'b1);
    checkOutput("errst_rise_restrt", {7'd0, RESTRT}, 8'h01);
    checkOutput("errst_rise_cause", {5'd0, CAUSE}, 8'd4);
    checkOutput("errst_rise_gojam", {7'd0, GOJAM}, 8'h01);
    checkOutput("errst_rise_stk", ALM_STK, 8'h00);

`ifdef ALARM_LOG_EN
    // Five restarts overflow the four-entry log; the first four causes pop out in order.
    doReset();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(8'(1 << c), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(8'h00, 1'b0, 1'b0);
    end
    checkOutput("log_ovf", {7'd0, LOG_OVF}, 8'h01);
    checkOutput("log_not_empty", {7'd0, LOG_EMPTY}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("log_pop%0d", k), {5'd0, LOG_DATA}, 8'(k));
      LOG_POP = 1'b1;
      applyStimulus(8'h00, 1'b0, 1'b0);
      LOG_POP = 1'b0;
    end
    checkOutput("log_empty", {7'd0, LOG_EMPTY}, 8'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
